seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and results; legal range 8..64.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 Port: aluop  input  4  operation select; sampled with start.
REQ-006 Port: a  input  WIDTH  operand A; sampled with start.
REQ-007 Port: b  input  WIDTH  operand B; sampled with start.
REQ-008 Port: out  output  WIDTH  registered primary result.
REQ-009 Port: hi  output  WIDTH  registered secondary result: product upper half for MUL, remainder for DIVU, 0 otherwise.
REQ-010 Port: zero  output  1  registered; 1 when out == 0.
REQ-011 Port: ovf  output  1  registered signed overflow flag for ADD/SUB; 0 for every other op.
REQ-012 Port: busy  output  1  1 while a multi-cycle op is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when out/hi/zero/ovf/err hold a new result.
REQ-014 Port: err  output  1  registered; 1 for illegal aluop or DIVU with b == 0.

Function
REQ-015 Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, out = 1 or 0); 1100 NOR; 1000 MUL (unsigned, 2*WIDTH product); 1001 DIVU (unsigned quotient/remainder); all others illegal.
REQ-016 States: IDLE, ITER, DONE; reset state IDLE.
REQ-017 IDLE + start + single-cycle op (incl. illegal): result registered at the accepting edge; next state DONE; busy stays 0.
REQ-018 IDLE + start + MUL, or DIVU with b != 0: operands latched, iteration counter = WIDTH, busy = 1 at the accepting edge; next state ITER.
REQ-019 ITER: one shift-add (MUL) or restoring shift-subtract (DIVU) step per edge; counter decrements; after the WIDTH-th step, result registered, busy = 0, next state DONE.
REQ-020 Latency: single-cycle ops, done high in the cycle after the accepting edge (1 cycle); MUL/DIVU, done high WIDTH+1 cycles after the accepting edge.
REQ-021 DONE: done = 1 for exactly one cycle, then IDLE; start in DONE is accepted like IDLE (back-to-back, no bubble).
REQ-022 start while busy = 1 ignored; operands and aluop changes during ITER do not affect the result.
REQ-023 Results, zero, ovf, err hold their values until the next result is registered.
REQ-024 ADD/SUB: out = low WIDTH bits (wrap-around); ovf = signed overflow of the WIDTH-bit operation.
REQ-025 DIVU b == 0: single-cycle; out = all ones, hi = a, err = 1.
REQ-026 Illegal aluop: out = 0, hi = 0, zero = 1, err = 1, done pulses normally.
REQ-027 MUL: {hi,out} = a*b exactly; DIVU: out = a/b, hi = a%b.

Reset
REQ-028 reset = 1 forces state IDLE, out = 0, hi = 0, zero = 0, ovf = 0, busy = 0, done = 0, err = 0, counter = 0, immediately and independent of clk.
REQ-029 reset asserted during ITER aborts the operation; no done pulse follows; first start after release is accepted normally.

Verification (WIDTH=32)
REQ-030 ADD a=0x7FFFFFFF b=1 -> next cycle out=0x80000000, ovf=1, zero=0, done=1, busy never 1.
REQ-031 SUB a=5 b=5 -> out=0, zero=1, ovf=0; SLT a=0xFFFFFFFF b=1 -> out=1.
REQ-032 MUL a=0xFFFFFFFF b=0xFFFFFFFF -> busy 1 for 32 cycles, done on cycle 33; hi=0xFFFFFFFE, out=0x00000001; start pulses during busy ignored.
REQ-033 DIVU a=100 b=7 -> out=14, hi=2, err=0 after 33 cycles; DIVU b=0 -> next cycle out=0xFFFFFFFF, hi=a, err=1.
REQ-034 aluop=1111 -> next cycle err=1, out=0, zero=1, done=1; back-to-back start in DONE cycle with ADD 1+2 -> out=3 one cycle later.
REQ-035 reset asserted mid-MUL (cycle 10) -> all outputs 0 asynchronously, no done; subsequent AND 0xF0F0 & 0xFF00 -> out=0xF000.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count, count_nx;
    logic [WIDTH:0]   acc, acc_nx;
    logic [WIDTH-1:0] lo, lo_nx;
    logic [WIDTH-1:0] opb, opb_nx;
    logic             div_op, div_op_nx;
    logic [WIDTH-1:0] out_nx, hi_nx;
    logic             zero_nx, ovf_nx, err_nx;

    logic [WIDTH-1:0] sum, dif;
    logic [WIDTH-1:0] sc_out, sc_hi;
    logic             sc_ovf, sc_err, multi;

    logic [WIDTH:0]   add_p, shl_r, sub_r;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] lo_step;

    assign sum  = a + b;
    assign dif  = a - b;
    assign busy = (state == ITER);
    assign done = (state == DONE);

    // Single-cycle results and detection of iterative ops
    always_comb begin
        sc_out = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        multi  = 1'b0;
        unique case (aluop)
            OP_AND: sc_out = a & b;
            OP_OR:  sc_out = a | b;
            OP_ADD: begin
                sc_out = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out = dif;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: sc_out = {{(WIDTH-1){1'b0}},
                              ($signed(a) < $signed(b))};
            OP_NOR: sc_out = ~(a | b);
            OP_MUL: multi = 1'b1;
            OP_DIVU: begin
                if (b == '0) begin
                    sc_out = '1;
                    sc_hi  = a;
                    sc_err = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration step; acc is the partial product or remainder
    always_comb begin
        add_p = acc + (lo[0] ? {1'b0, opb} : '0);
        shl_r = {acc[WIDTH-1:0], lo[WIDTH-1]};
        sub_r = shl_r - {1'b0, opb};
        if (!div_op) begin
            acc_step = {1'b0, add_p[WIDTH:1]};
            lo_step  = {add_p[0], lo[WIDTH-1:1]};
        end else if (sub_r[WIDTH]) begin
            acc_step = shl_r;
            lo_step  = {lo[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = sub_r;
            lo_step  = {lo[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        acc_nx    = acc;
        lo_nx     = lo;
        opb_nx    = opb;
        div_op_nx = div_op;
        out_nx    = out;
        hi_nx     = hi;
        zero_nx   = zero;
        ovf_nx    = ovf;
        err_nx    = err;
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (start && multi) begin
                    state_nx  = ITER;
                    count_nx  = CW'(WIDTH);
                    acc_nx    = '0;
                    div_op_nx = (aluop == OP_DIVU);
                    lo_nx     = (aluop == OP_MUL) ? b : a;
                    opb_nx    = (aluop == OP_MUL) ? a : b;
                end else if (start) begin
                    state_nx = DONE;
                    out_nx   = sc_out;
                    hi_nx    = sc_hi;
                    zero_nx  = (sc_out == '0);
                    ovf_nx   = sc_ovf;
                    err_nx   = sc_err;
                end
            end
            ITER: begin
                acc_nx   = acc_step;
                lo_nx    = lo_step;
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = DONE;
                    out_nx   = lo_step;
                    hi_nx    = acc_step[WIDTH-1:0];
                    zero_nx  = (lo_step == '0);
                    ovf_nx   = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            lo     <= '0;
            opb    <= '0;
            div_op <= 1'b0;
            out    <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            count  <= count_nx;
            acc    <= acc_nx;
            lo     <= lo_nx;
            opb    <= opb_nx;
            div_op <= div_op_nx;
            out    <= out_nx;
            hi     <= hi_nx;
            zero   <= zero_nx;
            ovf    <= ovf_nx;
            err    <= err_nx;
        end
    end
endmodule
